// File: rtl/servo_arbiter.sv
// Round-robin arbiter that grants one of four requesters exclusive use of a servo,
// drives its position for the requested number of milliseconds, then parks the servo.
module servo_arbiter #(
  parameter int          CLK_PER_MS = 50000,
  parameter logic [7:0]  HALT_POS   = 8'h50,
  parameter logic [11:0] SETTLE_MS  = 12'd2
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] req_pos,
  input  logic [47:0] req_ms,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic        busy,
  output logic [7:0]  motor_pos
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_MS - 1);

  typedef enum logic [2:0] {IDLE, GRANT, HOLD, SETTLE, DONE} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    winner;
  logic [7:0]    lat_pos;
  logic [11:0]   lat_ms;
  logic [PW-1:0] pre_cnt;
  logic [11:0]   ms_cnt;
  logic          aborted;

  logic [7:0]    pos_arr [4];
  logic [11:0]   ms_arr  [4];
  logic [1:0]    win;
  logic          pre_wrap;
  logic [11:0]   ms_inc;

  // First requester found scanning upward from p, wrapping 3 -> 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pos_arr[i] = req_pos[8*i +: 8];
      ms_arr[i]  = req_ms[12*i +: 12];
    end
    win      = rr_pick(req, ptr);
    pre_wrap = (pre_cnt == PRE_MAX);
    ms_inc   = ms_cnt + 12'd1;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      motor_pos <= HALT_POS;
      ptr       <= '0;
      pre_cnt   <= '0;
      ms_cnt    <= '0;
      aborted   <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          motor_pos <= HALT_POS;
          if (|req) begin
            winner  <= win;
            lat_pos <= pos_arr[win];
            lat_ms  <= (ms_arr[win] == 12'd0) ? 12'd1 : ms_arr[win];
            gnt     <= 4'b0001 << win;
            busy    <= 1'b1;
            aborted <= 1'b0;
            state   <= GRANT;
          end
        end

        GRANT: begin
          pre_cnt <= '0;
          ms_cnt  <= '0;
          if (!req[winner]) begin
            aborted   <= 1'b1;
            motor_pos <= HALT_POS;
            state     <= (SETTLE_MS == 12'd0) ? DONE : SETTLE;
          end else begin
            motor_pos <= lat_pos;
            state     <= HOLD;
          end
        end

        HOLD: begin
          if (!req[winner]) begin
            // Withdrawn mid-move: park immediately and still give the full settle time.
            aborted   <= 1'b1;
            motor_pos <= HALT_POS;
            pre_cnt   <= '0;
            ms_cnt    <= '0;
            state     <= (SETTLE_MS == 12'd0) ? DONE : SETTLE;
          end else if (pre_wrap) begin
            pre_cnt <= '0;
            if (ms_inc == lat_ms) begin
              ms_cnt    <= '0;
              motor_pos <= HALT_POS;
              if (SETTLE_MS == 12'd0) begin
                done  <= gnt;
                state <= DONE;
              end else begin
                state <= SETTLE;
              end
            end else begin
              ms_cnt <= ms_inc;
            end
          end else begin
            pre_cnt <= pre_cnt + 1'b1;
          end
        end

        SETTLE: begin
          motor_pos <= HALT_POS;
          if (pre_wrap) begin
            pre_cnt <= '0;
            if (ms_inc == SETTLE_MS) begin
              ms_cnt <= '0;
              done   <= aborted ? 4'b0000 : gnt;
              state  <= DONE;
            end else begin
              ms_cnt <= ms_inc;
            end
          end else begin
            pre_cnt <= pre_cnt + 1'b1;
          end
        end

        DONE: begin
          gnt       <= '0;
          busy      <= 1'b0;
          motor_pos <= HALT_POS;
          ptr       <= winner + 2'd1;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
